// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared constants, FSM states and LFSR step function for the noise path
package noise_pkg;

  localparam int          NOISE_W    = 24;
  localparam logic [23:0] NOISE_SEED = 24'h8964CE;

  // Feedback taps of the 24-bit Fibonacci LFSR
  localparam int TAP_A = 23;
  localparam int TAP_B = 3;
  localparam int TAP_C = 2;
  localparam int TAP_D = 0;

  typedef enum logic [1:0] {
    IDLE,
    ADVANCE,
    PRESENT
  } noise_state_e;

  // One LFSR shift; shared with noise_gen so both produce the same sequence
  function automatic logic [NOISE_W-1:0] lfsr_next(input logic [NOISE_W-1:0] l);
    return {l[NOISE_W-2:0], l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D]};
  endfunction

endpackage

// File: rtl/noise_lfsr_en.sv
// rtl/noise_lfsr_en.sv - enable-gated 24-bit LFSR with loadable seed
// A loaded zero is replaced by SEED so the register can never lock up.
module noise_lfsr_en
  import noise_pkg::*;
#(
  parameter logic [NOISE_W-1:0] SEED = NOISE_SEED
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               load_i,
  input  logic [NOISE_W-1:0] seed_i,
  output logic [NOISE_W-1:0] state_o
);

  logic [NOISE_W-1:0] state_q;

  // Load takes priority over a shift; zero seeds fall back to SEED
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else if (load_i) begin
      state_q <= (seed_i == '0) ? SEED : seed_i;
    end else if (en_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/noise_sched.sv
// rtl/noise_sched.sv - round-robin scheduler sharing one LFSR noise source among requesters
// The LFSR only moves while a sample is being produced, so each grant gets fresh noise.
module noise_sched
  import noise_pkg::*;
#(
  parameter int                 NUM_REQ = 4,
  parameter int                 STEPS   = 1,
  parameter logic [NOISE_W-1:0] SEED    = NOISE_SEED,
  localparam int                ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               reseed_i,
  input  logic [NOISE_W-1:0] seed_i,
  output logic [NOISE_W-1:0] noise_o,
  output logic [ID_W-1:0]    id_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               busy_o
);

  noise_state_e       state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [7:0]         step_cnt_q;
  logic [ID_W-1:0]    id_q;
  logic [NOISE_W-1:0] noise_q;
  logic               valid_q;
  logic               pend_q;
  logic [NOISE_W-1:0] pend_seed_q;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    rr_next;
  logic [ID_W-1:0]    cand_idx;
  int                 cand;

  logic               lfsr_en;
  logic               lfsr_load;
  logic [NOISE_W-1:0] load_val;
  logic [NOISE_W-1:0] lfsr_state;
  logic               do_grant;
  logic               do_present;
  logic               do_accept;

  noise_lfsr_en #(
    .SEED (SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (lfsr_en),
    .load_i  (lfsr_load),
    .seed_i  (load_val),
    .state_o (lfsr_state)
  );

  // Round-robin pick: first request at or after rr_ptr, wrapping past the top
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(rr_ptr_q) + i) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!grant_found && req_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    rr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a reseed in IDLE consumes the cycle so no grant happens
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!(reseed_i || pend_q) && grant_found) state_d = ADVANCE;
      end
      ADVANCE: begin
        if (step_cnt_q == 8'd1) state_d = PRESENT;
      end
      PRESENT: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM control outputs; a fresh reseed_i wins over an older pending seed
  always_comb begin
    lfsr_en    = 1'b0;
    lfsr_load  = 1'b0;
    load_val   = '0;
    do_grant   = 1'b0;
    do_present = 1'b0;
    do_accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (reseed_i) begin
          lfsr_load = 1'b1;
          load_val  = seed_i;
        end else if (pend_q) begin
          lfsr_load = 1'b1;
          load_val  = pend_seed_q;
        end else if (grant_found) begin
          do_grant = 1'b1;
        end
      end
      ADVANCE: begin
        lfsr_en = 1'b1;
        if (step_cnt_q == 8'd1) do_present = 1'b1;
      end
      PRESENT: begin
        if (ready_i) do_accept = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: grant bookkeeping, sample capture, handshake and deferred reseed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      step_cnt_q  <= '0;
      id_q        <= '0;
      noise_q     <= '0;
      valid_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_seed_q <= '0;
    end else begin
      if (reseed_i && state_q != IDLE) begin
        pend_q      <= 1'b1;
        pend_seed_q <= seed_i;
      end else if (lfsr_load) begin
        pend_q <= 1'b0;
      end

      if (do_grant) begin
        id_q       <= grant_idx;
        rr_ptr_q   <= rr_next;
        step_cnt_q <= 8'(STEPS);
      end else if (lfsr_en) begin
        step_cnt_q <= step_cnt_q - 8'd1;
      end

      if (do_present) begin
        noise_q <= lfsr_next(lfsr_state);
        valid_q <= 1'b1;
      end else if (do_accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign noise_o = noise_q;
  assign id_o    = id_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_noise_sched.sv
// tb/tb_noise_sched.sv - directed self-checking bench for noise_sched
module tb_noise_sched;

  localparam logic [23:0] SEED = 24'h8964CE;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic        reseed_i;
  logic [23:0] seed_i;
  logic        ready_i;

  logic [23:0] noise1, noise3;
  logic [1:0]  id1, id3;
  logic        valid1, valid3, busy1, busy3;

  int total = 0;
  int bad   = 0;
  logic [23:0] m_lfsr;

  always #5 clk_i = ~clk_i;

  noise_sched #(.NUM_REQ(4), .STEPS(1), .SEED(SEED)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .reseed_i(reseed_i), .seed_i(seed_i),
    .noise_o(noise1), .id_o(id1), .valid_o(valid1), .ready_i(ready_i), .busy_o(busy1)
  );

  noise_sched #(.NUM_REQ(4), .STEPS(3), .SEED(SEED)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .reseed_i(reseed_i), .seed_i(seed_i),
    .noise_o(noise3), .id_o(id3), .valid_o(valid3), .ready_i(ready_i), .busy_o(busy3)
  );

  function automatic logic [23:0] ref_step(input logic [23:0] v);
    return {v[22:0], v[23] ^ v[3] ^ v[2] ^ v[0]};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(input bit use3, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((use3 ? valid3 : valid1) !== 1'b1) && n < 50);
  endtask

  task automatic apply_reset();
    rst_i    = 1'b1;
    req_i    = '0;
    reseed_i = 1'b0;
    seed_i   = '0;
    ready_i  = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = '0; reseed_i = 1'b0; seed_i = '0; ready_i = 1'b0;
    #2;
    total++; if (valid1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL reset_ctrl got valid=%b busy=%b exp 0 0", valid1, busy1); end
    total++; if (noise1 !== 24'h0 || id1 !== 2'd0) begin bad++; $display("FAIL reset_data got noise=%h id=%0d exp 0 0", noise1, id1); end
    total++; if (valid3 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL reset_dut3 got valid=%b busy=%b exp 0 0", valid3, busy3); end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    tick();
    req_i = 4'b0001;
    tick();
    req_i = 4'b0000;
    total++; if (busy1 !== 1'b1 || valid1 !== 1'b0) begin bad++; $display("FAIL single_advance got busy=%b valid=%b exp 1 0", busy1, valid1); end
    tick();
    total++; if (valid1 !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", valid1); end
    total++; if (id1 !== 2'd0) begin bad++; $display("FAIL single_id got=%0d exp=0", id1); end
    total++; if (noise1 !== 24'h12C99D) begin bad++; $display("FAIL single_noise got=%h exp=12c99d", noise1); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (valid1 !== 1'b1 || noise1 !== 24'h12C99D) begin bad++; $display("FAIL single_hold%0d got valid=%b noise=%h exp 1 12c99d", i, valid1, noise1); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    ready_i = 1'b1;
    req_i   = 4'b0001;
    wait_valid(1'b0, n);
    total++; if (n != 3) begin bad++; $display("FAIL b2b_lat1 got=%0d exp=3", n); end
    total++; if (noise1 !== 24'h25933B || id1 !== 2'd0) begin bad++; $display("FAIL b2b_s1 got noise=%h id=%0d exp 25933b 0", noise1, id1); end
    wait_valid(1'b0, n);
    total++; if (n != 3) begin bad++; $display("FAIL b2b_interval got=%0d exp=3", n); end
    total++; if (noise1 !== 24'h4B2676) begin bad++; $display("FAIL b2b_s2 got=%h exp=4b2676", noise1); end
    req_i = 4'b0000;
    tick();
    total++; if (valid1 !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b exp=0", valid1); end
    ready_i = 1'b0;
  endtask

  task automatic test_rr_all();
    int n;
    int exp_id[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    m_lfsr  = SEED;
    req_i   = 4'b1111;
    ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid(1'b0, n);
      m_lfsr = ref_step(m_lfsr);
      total++; if (n != ((k == 0) ? 2 : 3)) begin bad++; $display("FAIL rr_lat%0d got=%0d exp=%0d", k, n, (k == 0) ? 2 : 3); end
      total++; if (id1 !== 2'(exp_id[k])) begin bad++; $display("FAIL rr_id%0d got=%0d exp=%0d", k, id1, exp_id[k]); end
      total++; if (noise1 !== m_lfsr) begin bad++; $display("FAIL rr_noise%0d got=%h exp=%h", k, noise1, m_lfsr); end
      if (k == 3) begin
        total++; if (noise1 !== 24'h964CED) begin bad++; $display("FAIL rr_four_shifts got=%h exp=964ced", noise1); end
      end
    end
    req_i = 4'b0000;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_steps3();
    int n;
    apply_reset();
    req_i   = 4'b0001;
    ready_i = 1'b0;
    wait_valid(1'b1, n);
    total++; if (n != 4) begin bad++; $display("FAIL steps3_lat got=%0d exp=4", n); end
    total++; if (noise3 !== 24'h4B2676 || id3 !== 2'd0) begin bad++; $display("FAIL steps3_noise got noise=%h id=%0d exp 4b2676 0", noise3, id3); end
    req_i   = 4'b0000;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    total++; if (valid3 !== 1'b0) begin bad++; $display("FAIL steps3_accept got=%b exp=0", valid3); end
  endtask

  task automatic test_reseed();
    int n;
    apply_reset();
    req_i = 4'b0001;
    wait_valid(1'b0, n);
    ready_i = 1'b1;
    req_i   = 4'b0000;
    tick();
    ready_i = 1'b0;
    // zero seed in IDLE together with a request: load only, no grant
    reseed_i = 1'b1;
    seed_i   = 24'h000000;
    req_i    = 4'b0001;
    tick();
    reseed_i = 1'b0;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reseed_nogrant got busy=%b exp=0", busy1); end
    wait_valid(1'b0, n);
    total++; if (n != 2 || noise1 !== 24'h12C99D) begin bad++; $display("FAIL reseed_zero got n=%0d noise=%h exp 2 12c99d", n, noise1); end
    req_i = 4'b0000;
    // reseed while presenting, then overwrite it in the handshake cycle
    reseed_i = 1'b1;
    seed_i   = 24'hABCDEF;
    tick();
    total++; if (valid1 !== 1'b1 || noise1 !== 24'h12C99D) begin bad++; $display("FAIL reseed_present got valid=%b noise=%h exp 1 12c99d", valid1, noise1); end
    seed_i  = 24'h000001;
    ready_i = 1'b1;
    tick();
    reseed_i = 1'b0;
    ready_i  = 1'b0;
    total++; if (valid1 !== 1'b0) begin bad++; $display("FAIL reseed_handshake got=%b exp=0", valid1); end
    req_i = 4'b0001;
    wait_valid(1'b0, n);
    total++; if (n != 3) begin bad++; $display("FAIL reseed_pend_lat got=%0d exp=3", n); end
    total++; if (noise1 !== 24'h000003) begin bad++; $display("FAIL reseed_pend_noise got=%h exp=000003", noise1); end
    req_i   = 4'b0000;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int n;
    apply_reset();
    req_i = 4'b0001;
    tick();
    req_i = 4'b0000;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy1); end
    rst_i = 1'b1;
    #1;
    total++; if (valid1 !== 1'b0 || busy1 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL mid_async got valid=%b busy=%b busy3=%b exp 0 0 0", valid1, busy1, busy3); end
    tick();
    rst_i = 1'b0;
    req_i = 4'b0001;
    wait_valid(1'b0, n);
    req_i = 4'b0000;
    total++; if (n != 2 || noise1 !== 24'h12C99D) begin bad++; $display("FAIL mid_first got n=%0d noise=%h exp 2 12c99d", n, noise1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_all();
    test_steps3();
    test_reseed();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
